// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan sequencer: sample word layout,
// scan FSM encoding and the channel-select helper.
package adc_pkg;

  localparam int ADC_BITS    = 10;
  localparam int CHAN_BITS   = 3;
  localparam int SAMPLE_BITS = 13;
  localparam int NUM_CHAN    = 8;

  localparam int DATA_LSB = 0;
  localparam int CHAN_LSB = ADC_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT_READY,
    S_TRIG,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_CAPTURE
  } scan_state_t;

  function automatic logic [SAMPLE_BITS-1:0] pack_sample(input logic [CHAN_BITS-1:0] ch,
                                                         input logic [ADC_BITS-1:0]  data);
    logic [SAMPLE_BITS-1:0] s;
    s = '0;
    s[CHAN_LSB +: CHAN_BITS] = ch;
    s[DATA_LSB +: ADC_BITS]  = data;
    return s;
  endfunction

  // Lowest set bit wins, so channels are converted in ascending order.
  function automatic logic [CHAN_BITS-1:0] lowest_chan(input logic [NUM_CHAN-1:0] mask);
    logic [CHAN_BITS-1:0] ch;
    ch = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (mask[i]) ch = CHAN_BITS'(i);
    end
    return ch;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through result FIFO; a push into a full FIFO is dropped
// (flagged on o_drop) unless a pop frees a slot in the same cycle.
module sample_fifo #(
  parameter int DATA_W = 13,
  parameter int DEPTH  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Head is forced to zero while empty so the output is defined out of reset.
  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_drop  = i_push && !w_do_push;

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic ADC channel scanner: one trigger/OutVal handshake per selected
// channel, results queued as {channel, data} words with sticky error flags.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int PERIOD_CLKS  = 50000,
  parameter int FIFO_DEPTH   = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [NUM_CHAN-1:0]    chan_mask,
  input  logic                   diffn_cfg,
  output logic                   adc_trigger,
  output logic [CHAN_BITS-1:0]   adc_channel,
  output logic                   adc_diffn,
  input  logic [ADC_BITS-1:0]    adc_dout,
  input  logic                   adc_outval,
  input  logic                   rd_en,
  output logic [SAMPLE_BITS-1:0] rd_data,
  output logic                   rd_empty,
  output logic [6:0]             rd_count,
  output logic                   overrun,
  output logic                   missed_tick,
  output logic                   timeout_err,
  input  logic                   clear_status
);

  localparam int PCNT_W = $clog2(PERIOD_CLKS);
  localparam int TCNT_W = $clog2(BUSY_TIMEOUT);
  localparam logic [PCNT_W-1:0] PERIOD_RELOAD = PCNT_W'(PERIOD_CLKS - 1);
  // Loaded in TRIG so the flag rises BUSY_TIMEOUT clocks after the trigger clock.
  localparam logic [TCNT_W-1:0] TIMEOUT_LOAD  = TCNT_W'(BUSY_TIMEOUT - 2);

  scan_state_t          r_state;
  logic [PCNT_W-1:0]    r_period_cnt;
  logic [TCNT_W-1:0]    r_tcnt;
  logic [NUM_CHAN-1:0]  r_scan_mask;
  logic [CHAN_BITS-1:0] r_chan;
  logic [ADC_BITS-1:0]  r_sample;
  logic                 r_trig;
  logic                 r_diffn;
  logic                 r_overrun;
  logic                 r_missed;
  logic                 r_timeout;

  logic                       w_tick;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_timeout;
  logic [SAMPLE_BITS-1:0]     w_word;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

  assign w_tick    = enable && (r_period_cnt == '0);
  assign w_push    = (r_state == S_CAPTURE);
  assign w_timeout = (r_state == S_WAIT_LOW) && adc_outval && (r_tcnt == '0);
  assign w_word    = pack_sample(r_chan, r_sample);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_period_cnt <= PERIOD_RELOAD;
    end else if (!enable || r_period_cnt == '0) begin
      r_period_cnt <= PERIOD_RELOAD;
    end else begin
      r_period_cnt <= r_period_cnt - PCNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_scan_mask <= '0;
      r_chan      <= '0;
      r_tcnt      <= '0;
      r_trig      <= 1'b0;
      r_diffn     <= 1'b0;
    end else begin
      r_diffn <= diffn_cfg;
      case (r_state)
        S_IDLE: begin
          if (w_tick && chan_mask != '0) begin
            r_scan_mask <= chan_mask;
            r_state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_scan_mask == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_chan      <= lowest_chan(r_scan_mask);
            r_scan_mask <= r_scan_mask & (r_scan_mask - NUM_CHAN'(1));
            r_state     <= S_WAIT_READY;
          end
        end
        S_WAIT_READY: begin
          if (adc_outval) begin
            r_trig  <= 1'b1;
            r_state <= S_TRIG;
          end
        end
        S_TRIG: begin
          r_trig  <= 1'b0;
          r_tcnt  <= TIMEOUT_LOAD;
          r_state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!adc_outval)       r_state <= S_WAIT_HIGH;
          else if (r_tcnt == '0) r_state <= S_SELECT;
          else                   r_tcnt  <= r_tcnt - TCNT_W'(1);
        end
        S_WAIT_HIGH: begin
          if (adc_outval) r_state <= S_CAPTURE;
        end
        S_CAPTURE: r_state <= S_SELECT;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == S_WAIT_HIGH && adc_outval) r_sample <= adc_dout;
  end

  // Sticky flags: a set event in the same cycle as clear_status wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
      r_missed  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_drop)                            r_overrun <= 1'b1;
      else if (clear_status)                 r_overrun <= 1'b0;
      if (w_tick && r_state != S_IDLE)       r_missed  <= 1'b1;
      else if (clear_status)                 r_missed  <= 1'b0;
      if (w_timeout)                         r_timeout <= 1'b1;
      else if (clear_status)                 r_timeout <= 1'b0;
    end
  end

  sample_fifo #(
    .DATA_W (SAMPLE_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (rd_en),
    .o_data  (rd_data),
    .o_empty (rd_empty),
    .o_count (w_fifo_count),
    .o_drop  (w_drop)
  );

  assign adc_trigger = r_trig;
  assign adc_channel = r_chan;
  assign adc_diffn   = r_diffn;
  assign rd_count    = 7'(w_fifo_count);
  assign overrun     = r_overrun;
  assign missed_tick = r_missed;
  assign timeout_err = r_timeout;

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Downstream consumer of the Mercury2 ADC interface. It periodically scans a programmable set of ADC channels, one conversion at a time, using the trigger/OutVal handshake. Each result is captured as a {channel, data} word and pushed into a small FIFO for the host-side readout logic. Sticky status flags report FIFO overrun, missed scan ticks and ADC handshake timeouts.

Parameters:
PERIOD_CLKS, 50000, scan start interval in clocks (1 ms at 50 MHz); legal range 2..2^20
FIFO_DEPTH, 16, result FIFO depth in entries; power of two, 4..64
BUSY_TIMEOUT, 15, max clocks allowed for OutVal to fall after trigger

Ports:
clock  in  1  50 MHz system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = generate periodic scans
chan_mask  in  8  bit i = include channel i in each scan
diffn_cfg  in  1  passed to adc_diffn (single-ended/differential)
adc_trigger  out  1  one-clock conversion request to ADC interface
adc_channel  out  3  channel for the current conversion, held stable trigger..capture
adc_diffn  out  1  equals diffn_cfg, registered
adc_dout  in  10  ADC result
adc_outval  in  1  ADC idle/result valid
rd_en  in  1  pop one FIFO word (ignored when empty)
rd_data  out  13  {channel[2:0], data[9:0]} at FIFO head, first-word-fall-through
rd_empty  out  1  FIFO empty
rd_count  out  7  words in FIFO
overrun  out  1  sticky: result dropped because FIFO full
missed_tick  out  1  sticky: period tick arrived while scan busy
timeout_err  out  1  sticky: OutVal failed to fall within BUSY_TIMEOUT
clear_status  in  1  synchronous clear of the three sticky flags

Behaviour:
- Reset: all outputs 0 except rd_empty=1. FSM=IDLE, period counter=PERIOD_CLKS-1, FIFO empty.
- Period counter: while enable=1, decrement each clock; at 0, pulse tick and reload PERIOD_CLKS-1. While enable=0, hold at reload value; no ticks. A scan in progress always completes.
- FSM states: IDLE, SELECT, WAIT_READY, TRIG, WAIT_LOW, WAIT_HIGH, CAPTURE.
- IDLE: on tick with chan_mask!=0, latch chan_mask into scan_mask and go to SELECT. On tick with mask=0, do nothing.
- SELECT: pick the lowest set bit of scan_mask, drive adc_channel, clear that bit, go to WAIT_READY. If scan_mask=0, go to IDLE.
- WAIT_READY: wait for adc_outval=1, then go to TRIG.
- TRIG: adc_trigger=1 for exactly this one clock. Load the timeout counter. Go to WAIT_LOW.
- WAIT_LOW: adc_outval=0 goes to WAIT_HIGH. If the counter expires first, set timeout_err, discard the conversion and go to SELECT.
- WAIT_HIGH: wait without limit for adc_outval=1, then go to CAPTURE.
- CAPTURE: sample adc_dout in the first cycle OutVal is high again. Push {adc_channel, adc_dout} to the FIFO, then go to SELECT.
- Tick while FSM != IDLE: the tick is dropped and missed_tick is set.
- FIFO full on push: the word is dropped, overrun is set, and contents are unchanged.
- Push and pop in the same cycle: legal at any fill level except a pop when empty. A full FIFO with simultaneous pop and push accepts the push.
- rd_count is exact 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- clear_status in the same cycle as a set event: set wins.
- chan_mask changes mid-scan have no effect until the next scan.
- Reset mid-conversion: FSM returns to IDLE and adc_trigger=0. The next conversion still waits for adc_outval=1, so a stale ADC busy period is tolerated.
- Latency: about 3 clocks from tick to first trigger when ADC is idle, plus ADC busy time per channel. Capture-to-rd_empty falling is 1 clock.

Decomposition:
- Shared package adc_pkg holds:
  - ADC_BITS=10, CHAN_BITS=3, SAMPLE_BITS=13
  - the FSM state encoding
  - the sample word field offsets
- Natural sub-module: sample_fifo, a synchronous first-word-fall-through FIFO parameterised by width and depth, with full/empty/count and the overrun drop rule.

Test Plan:
- Use a bench ADC model with 82-clock busy. chan_mask=8'h05, PERIOD_CLKS=400, enable 1 tick -> two triggers with channel 0 then 2. FIFO holds {0,d0},{2,d1}, rd_count=2, no flags.
- chan_mask=8'hFF, PERIOD_CLKS=300 -> scan takes about 700 clocks, so missed_tick=1. Results keep channel order 0..7.
- FIFO_DEPTH=4, mask=8'h3F, no reads -> 4 words stored, overrun=1, rd_count=4. rd_en pop then clear_status -> overrun=0, count=3.
- ADC model never drops OutVal -> timeout_err set 15 clocks after trigger. No FIFO write. The next channel is still attempted.
- Assert reset_n low in WAIT_HIGH -> all outputs at reset values immediately (asynchronous). After release, the first trigger waits for OutVal=1.
- enable=0 mid-scan -> the current scan completes, then no further triggers for 2×PERIOD_CLKS.
